matmul_ctrl_seq: RTL and testbench

//  Consumer side of the 16-bit matmul control register: decodes the control word, runs one

---
 rtl/matmul_ctrl_seq.sv | 180 ++++++++++++++++++
 tb/tb_matmul_ctrl_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/matmul_ctrl_seq.sv
// Matmul control sequencer: latches the control word on a start edge and walks LOAD_A, LOAD_B, COMPUTE, WRITEBACK, DONE.
// Outputs are registered and valid in the cycle their state occupies; writeback stalls in place while wr_ready_i is low.
module matmul_ctrl_seq #(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [15:0]       ctrl_reg_i,
    output logic              rd_en_o,
    output logic              rd_sel_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              pe_en_o,
    output logic              acc_en_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [1:0]        wr_target_o,
    input  logic              wr_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              clear_start_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_COMPUTE,
        S_WRITEBACK,
        S_DONE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [4:0]        r_cnt, w_cnt_nxt;
    logic              r_start_q;
    logic              w_launch;
    logic [2:0]        r_n, r_k, r_m;
    logic              r_mode, r_reload_a, r_reload_b;
    logic [1:0]        r_wr_target;
    logic [4:0]        w_nk, w_km, w_nm, w_cyc;
    logic              w_mode_eff;

    logic              r_rd_en, r_rd_sel, r_pe_en, r_acc_en, r_wr_en;
    logic              r_busy, r_done, r_err;
    logic [ADDR_W-1:0] r_rd_addr, r_wr_addr;
    logic              w_rd_en, w_rd_sel, w_pe_en, w_acc_en, w_wr_en, w_busy, w_done;
    logic [ADDR_W-1:0] w_rd_addr, w_wr_addr;

    assign w_launch = ctrl_reg_i[0] & ~r_start_q;
    assign w_nk     = {2'b00, r_n} * {2'b00, r_k};
    assign w_km     = {2'b00, r_k} * {2'b00, r_m};
    assign w_nm     = {2'b00, r_n} * {2'b00, r_m};
    assign w_cyc    = {2'b00, r_k} + {2'b00, r_n} + {2'b00, r_m} - 5'd2;
    // Mode is not latched yet when IDLE launches straight into COMPUTE.
    assign w_mode_eff = (r_state == S_IDLE) ? ctrl_reg_i[1] : r_mode;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_cnt_nxt = 5'd0;
                    if (ctrl_reg_i[14])      w_state_nxt = S_LOAD_A;
                    else if (ctrl_reg_i[15]) w_state_nxt = S_LOAD_B;
                    else                     w_state_nxt = S_COMPUTE;
                end
            end
            S_LOAD_A: begin
                if (r_cnt == w_nk - 5'd1) begin
                    w_cnt_nxt   = 5'd0;
                    w_state_nxt = r_reload_b ? S_LOAD_B : S_COMPUTE;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            S_LOAD_B: begin
                if (r_cnt == w_km - 5'd1) begin
                    w_cnt_nxt   = 5'd0;
                    w_state_nxt = S_COMPUTE;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            S_COMPUTE: begin
                if (r_cnt == w_cyc - 5'd1) begin
                    w_cnt_nxt   = 5'd0;
                    w_state_nxt = S_WRITEBACK;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            S_WRITEBACK: begin
                if (wr_ready_i) begin
                    if (r_cnt == w_nm - 5'd1) begin
                        w_cnt_nxt   = 5'd0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + 5'd1;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // Output strobes are decoded from the next state so the flops line up with it.
        w_rd_en   = (w_state_nxt == S_LOAD_A) || (w_state_nxt == S_LOAD_B);
        w_rd_sel  = (w_state_nxt == S_LOAD_B);
        w_rd_addr = w_rd_en ? ADDR_W'(w_cnt_nxt) : '0;
        w_pe_en   = (w_state_nxt == S_COMPUTE);
        w_acc_en  = w_pe_en & w_mode_eff;
        w_wr_en   = (w_state_nxt == S_WRITEBACK);
        w_wr_addr = w_wr_en ? ADDR_W'(w_cnt_nxt) : '0;
        w_busy    = (w_state_nxt != S_IDLE);
        w_done    = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= 5'd0;
            r_start_q   <= 1'b0;
            r_n         <= 3'd0;
            r_k         <= 3'd0;
            r_m         <= 3'd0;
            r_mode      <= 1'b0;
            r_reload_a  <= 1'b0;
            r_reload_b  <= 1'b0;
            r_wr_target <= 2'd0;
            r_rd_en     <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_rd_addr   <= '0;
            r_pe_en     <= 1'b0;
            r_acc_en    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_start_q <= ctrl_reg_i[0];
            if ((r_state == S_IDLE) && w_launch) begin
                r_n         <= {1'b0, ctrl_reg_i[9:8]} + 3'd1;
                r_k         <= {1'b0, ctrl_reg_i[11:10]} + 3'd1;
                r_m         <= {1'b0, ctrl_reg_i[13:12]} + 3'd1;
                r_mode      <= ctrl_reg_i[1];
                r_wr_target <= ctrl_reg_i[3:2];
                r_reload_a  <= ctrl_reg_i[14];
                r_reload_b  <= ctrl_reg_i[15];
            end
            r_rd_en   <= w_rd_en;
            r_rd_sel  <= w_rd_sel;
            r_rd_addr <= w_rd_addr;
            r_pe_en   <= w_pe_en;
            r_acc_en  <= w_acc_en;
            r_wr_en   <= w_wr_en;
            r_wr_addr <= w_wr_addr;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_err     <= w_launch & (r_state != S_IDLE);
        end
    end

    assign rd_en_o       = r_rd_en;
    assign rd_sel_o      = r_rd_sel;
    assign rd_addr_o     = r_rd_addr;
    assign pe_en_o       = r_pe_en;
    assign acc_en_o      = r_acc_en;
    assign wr_en_o       = r_wr_en;
    assign wr_addr_o     = r_wr_addr;
    assign wr_target_o   = r_wr_target;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign clear_start_o = r_done;
    assign err_o         = r_err;

endmodule

// File: tb/tb_matmul_ctrl_seq.sv
// Directed bench for matmul_ctrl_seq: per-run phase counters compared against hand-computed counts.
module tb_matmul_ctrl_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ctrl = 16'h0000;
    logic        wr_ready = 1'b1;

    logic       o_rd_en, o_rd_sel, o_pe_en, o_acc_en, o_wr_en;
    logic       o_busy, o_done, o_clr, o_err;
    logic [3:0] o_rd_addr, o_wr_addr;
    logic [1:0] o_wr_target;
    logic [18:0] outvec;

    int n_checks = 0;
    int n_errors = 0;
    int busy_n, done_at, na, nb, a_bad, b_bad, npe, nacc, nwr, w_bad;
    int nerr, ndone, nclr, n_addr1, stalls, wt;
    bit finished;

    always #5 clk = ~clk;

    assign outvec = {o_rd_en, o_rd_sel, o_rd_addr, o_pe_en, o_acc_en, o_wr_en, o_wr_addr,
                     o_wr_target, o_busy, o_done, o_clr, o_err};

    matmul_ctrl_seq #(.ADDR_W(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ctrl_reg_i   (ctrl),
        .rd_en_o      (o_rd_en),
        .rd_sel_o     (o_rd_sel),
        .rd_addr_o    (o_rd_addr),
        .pe_en_o      (o_pe_en),
        .acc_en_o     (o_acc_en),
        .wr_en_o      (o_wr_en),
        .wr_addr_o    (o_wr_addr),
        .wr_target_o  (o_wr_target),
        .wr_ready_i   (wr_ready),
        .busy_o       (o_busy),
        .done_o       (o_done),
        .clear_start_o(o_clr),
        .err_o        (o_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Launch one operation and tally every strobe until busy drops again.
    task automatic run_op(input logic [15:0] cfg, input int stall_addr, input bit toggle,
                          input bit scramble);
        bit seen;
        seen = 0; finished = 0;
        busy_n = 0; done_at = 0; na = 0; nb = 0; a_bad = 0; b_bad = 0; npe = 0; nacc = 0;
        nwr = 0; w_bad = 0; nerr = 0; ndone = 0; nclr = 0; n_addr1 = 0; stalls = 0; wt = -1;
        @(negedge clk);
        ctrl = cfg & 16'hFFFE;
        wr_ready = 1'b1;
        @(negedge clk);
        ctrl = cfg | 16'h0001;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!o_busy && seen) begin
                finished = 1;
                break;
            end
            if (o_busy) begin
                seen = 1;
                busy_n++;
            end
            if (o_rd_en && !o_rd_sel) begin
                if (int'(o_rd_addr) != na) a_bad++;
                na++;
            end
            if (o_rd_en && o_rd_sel) begin
                if (int'(o_rd_addr) != nb) b_bad++;
                nb++;
            end
            if (o_pe_en) begin
                npe++;
                if (o_acc_en) nacc++;
                if (toggle && npe == 1) ctrl[0] = 1'b0;
                if (toggle && npe == 2) ctrl[0] = 1'b1;
            end
            if (o_err) nerr++;
            if (o_wr_en) begin
                if (o_wr_addr == 4'd1) n_addr1++;
                if (wt < 0) wt = int'(o_wr_target);
                if (stall_addr >= 0 && int'(o_wr_addr) == stall_addr && stalls < 3) begin
                    wr_ready = 1'b0;
                    stalls++;
                end else begin
                    wr_ready = 1'b1;
                end
                if (wr_ready) begin
                    if (int'(o_wr_addr) != nwr) w_bad++;
                    nwr++;
                end
            end else begin
                wr_ready = 1'b1;
            end
            if (o_done) begin
                ndone++;
                done_at = busy_n;
            end
            if (o_clr) nclr++;
            if (scramble && busy_n == 3) ctrl = 16'h0001;
        end
        wr_ready = 1'b1;
    endtask

    task automatic chk_run(input string t, input int e_busy, input int e_na, input int e_nb,
                           input int e_pe, input int e_acc, input int e_wr, input int e_err);
        chk({t, "_finished"}, finished, 1);
        chk({t, "_busy_cycles"}, busy_n, e_busy);
        chk({t, "_done_cycle"}, done_at, e_busy);
        chk({t, "_a_reads"}, na, e_na);
        chk({t, "_b_reads"}, nb, e_nb);
        chk({t, "_rd_addr_order"}, a_bad + b_bad, 0);
        chk({t, "_pe_cycles"}, npe, e_pe);
        chk({t, "_acc_cycles"}, nacc, e_acc);
        chk({t, "_writes"}, nwr, e_wr);
        chk({t, "_wr_addr_order"}, w_bad, 0);
        chk({t, "_err_pulses"}, nerr, e_err);
        chk({t, "_done_pulses"}, ndone, 1);
        chk({t, "_clear_pulses"}, nclr, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", outvec, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", outvec, 0);

        // 1x1x1, both reloads
        run_op(16'hC000, -1, 0, 0);
        chk_run("t1", 5, 1, 1, 1, 0, 1, 0);
        repeat (5) @(negedge clk);
        chk("t1_no_retrigger", o_busy, 0);

        // 4x4x4, write_target=2, reserved fields set, config scrambled while busy
        run_op(16'hFFF8, -1, 0, 1);
        chk_run("t2", 59, 16, 16, 10, 0, 16, 0);
        chk("t2_wr_target", wt, 2);

        // n=2,k=3,m=1, no reloads, accumulate mode
        run_op(16'h0902, -1, 0, 0);
        chk_run("t3", 7, 0, 0, 4, 4, 2, 0);

        // n=1,k=1,m=2, reload_b only, stall 3 cycles on write addr 1
        run_op(16'h9000, 1, 0, 0);
        chk_run("t4", 10, 0, 2, 2, 0, 2, 0);
        chk("t4_addr1_hold", n_addr1, 4);

        // 2x2x2, start re-edged during COMPUTE
        run_op(16'hD500, -1, 1, 0);
        chk_run("t5", 17, 4, 4, 4, 0, 4, 1);

        // Reset in the middle of writeback
        @(negedge clk);
        ctrl = 16'hFFF8;
        @(negedge clk);
        ctrl = 16'hFFF9;
        finished = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (o_wr_en && o_wr_addr == 4'd5) begin
                finished = 1;
                break;
            end
        end
        chk("t6_reach_wb", finished, 1);
        rst = 1'b1;
        #1;
        chk("t6_async_outputs", outvec, 0);
        @(posedge clk);
        #1;
        chk("t6_held_outputs", outvec, 0);
        ctrl = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_idle_after", outvec, 0);
        run_op(16'hC000, -1, 0, 0);
        chk_run("t6_rerun", 5, 1, 1, 1, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
